cluster_icache_flush_seq: RTL and testbench
===========================================

Name: cluster_icache_flush_seq

Overview:
- Sequences instruction-cache flushes requested by the icache control unit.
- Accepts per-fetch-port flush pulses and batches them.
- Flushes the shared L1 first, then the selected L0 caches, using valid/ready handshakes.
- Drives per-port flush_ready back to the control unit, so software status reads stay busy until each port's flush has completed.

Parameters:
- NR_FETCH_PORTS, 4, number of L0/fetch ports; legal range 1..32.
- L1_FLUSH_EN, 1, 1 = flush L1 once per batch; 0 = skip the L1 state.
- CYC_W, 16, width of the saturating last-batch cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_valid_i  in  NR_FETCH_PORTS  flush request pulses from the control unit; may be multi-bit.
- flush_ready_o  out  NR_FETCH_PORTS  1 = port idle (no request pending or in flight).
- l1_flush_valid_o  out  1  L1 flush request.
- l1_flush_ready_i  in  1  L1 flush complete.
- l0_flush_valid_o  out  NR_FETCH_PORTS  per-L0 flush request.
- l0_flush_ready_i  in  NR_FETCH_PORTS  per-L0 flush complete.
- busy_o  out  1  FSM not in IDLE.
- last_flush_cycles_o  out  CYC_W  duration of the most recent completed batch, saturating.

Behaviour:
- Registers: pending[N], batch[N], l0_done[N], state, cyc_cnt, last_cyc.
- Reset values: all registers 0 and state IDLE, so after reset flush_ready_o = all 1, every valid = 0, busy_o = 0, last_flush_cycles_o = 0.
- Reset mid-operation: an in-flight handshake is abandoned and its valid drops on the next cycle. Downstream caches must tolerate this; it is only legal when they are also in reset.
- Request capture: pending |= flush_valid_i every cycle, regardless of state.
  - A pulse for a port already in pending or batch is merged, not queued twice.
- flush_ready_o[i] = ~(pending[i] | batch[i]). It is combinational from registers only, with no path from flush_valid_i.
- FSM:
  - IDLE: if |pending, then batch <= pending; pending <= flush_valid_i (same-cycle pulses go to the next batch); cyc_cnt <= 1; go to L1 if L1_FLUSH_EN, else to L0.
  - L1: l1_flush_valid_o = 1. On l1_flush_ready_i, go to L0 (valid drops next cycle).
  - L0: l0_flush_valid_o = batch & ~l0_done. l0_done |= l0_flush_valid_o & l0_flush_ready_i. When (l0_done | handshake-this-cycle) covers batch, go to DONE.
  - DONE (1 cycle): batch <= 0; l0_done <= 0; last_cyc <= cyc_cnt; go to IDLE.
- Per-port release: ports flushed in a batch see flush_ready_o rise in the cycle after DONE.
- cyc_cnt increments in L1, L0 and DONE, and saturates at 2^CYC_W-1.
- Handshake rules:
  - A valid, once raised, stays high until its ready is seen.
  - Ready without valid is ignored.
  - Ports' L0 handshakes complete independently and in any order.
- Ordering: L1 always completes before any L0 valid rises. This prevents L0 refills from stale L1 lines.
- Minimum latency: pulse at cycle t, with L1 ready tied high and L0 ready tied high:
  - t+1: IDLE sees pending.
  - t+2: L1.
  - t+3: L0.
  - t+4: DONE.
  - t+5: flush_ready_o high.
- Simultaneous events: requests arriving in any non-IDLE state accumulate in pending and form exactly one follow-up batch. No request is ever lost.

Decomposition:
- Package cluster_icache_flush_pkg holds the state enum (IDLE, L1, L0, DONE) and a localparam for saturating-increment width checks.
- The FSM and handshake logic live in the top module.
- One natural sub-module, cluster_icache_sat_cnt: a parameterised saturating counter with clear/load/increment, reused for cyc_cnt.

Test Plan:
- Single port, all readies tied 1: N=4, flush_valid_i=4'b0100 for 1 cycle at t=10 -> l1_flush_valid_o high at t=12; l0_flush_valid_o=4'b0100 at t=13; flush_ready_o[2] low t=11..14, high at t=15; last_flush_cycles_o=3.
- Backpressure: l1_flush_ready_i held low 20 cycles -> l1_flush_valid_o stable high 20 cycles, no l0 valid; then last_flush_cycles_o=23.
- Out-of-order L0 completion: batch 4'b1011; ready order port3, port0, port1 at spaced cycles -> each valid drops the cycle after its handshake; DONE only after port1.
- Request during batch: pulse 4'b0001, then 4'b0011 while in L0 -> first batch = 4'b0001; second batch = 4'b0011 with a second L1 flush; flush_ready_o[0] stays low continuously until the second DONE.
- L1_FLUSH_EN=0: pulse 4'b1111 -> l1_flush_valid_o never asserted; all four L0 valids rise at t+2.
- Reset in L0 state with rst_i high for 1 cycle -> next cycle all valids 0, flush_ready_o=4'b1111, busy_o=0; a subsequent pulse runs a normal batch.

Source files
------------

// File: rtl/cluster_icache_flush_pkg.sv
// Shared types and constants for the instruction-cache flush sequencer.
package cluster_icache_flush_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StL1,
    StL0,
    StDone
  } flush_state_e;

  // Widest saturating counter the sequencer is meant to be built with.
  localparam int unsigned SatCntMaxW = 32;

endpackage

// File: rtl/cluster_icache_sat_cnt.sv
// Saturating up-counter with synchronous clear, load and increment.
module cluster_icache_sat_cnt
  import cluster_icache_flush_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  if (Width < 1 || Width > SatCntMaxW) begin : gen_width_chk
    $error("cluster_icache_sat_cnt: Width out of range");
  end

  logic [Width-1:0] cnt_q, cnt_d;

  // Priority: clear, load, increment; increment holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cluster_icache_flush_seq.sv
// Batches per-port icache flush requests and sequences L1 then L0 flushes
// over valid/ready handshakes, holding each port busy until its flush is done.
module cluster_icache_flush_seq
  import cluster_icache_flush_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter bit          L1_FLUSH_EN    = 1'b1,
  parameter int unsigned CYC_W          = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NR_FETCH_PORTS-1:0] flush_valid_i,
  output logic [NR_FETCH_PORTS-1:0] flush_ready_o,
  output logic                      l1_flush_valid_o,
  input  logic                      l1_flush_ready_i,
  output logic [NR_FETCH_PORTS-1:0] l0_flush_valid_o,
  input  logic [NR_FETCH_PORTS-1:0] l0_flush_ready_i,
  output logic                      busy_o,
  output logic [CYC_W-1:0]          last_flush_cycles_o
);

  localparam int unsigned N = NR_FETCH_PORTS;

  flush_state_e     state_q;
  logic [N-1:0]     pending_q, batch_q, l0_done_q;
  logic [N-1:0]     l0_valid, l0_hs, l0_done_nxt;
  logic [CYC_W-1:0] cyc_cnt, last_cyc_q;
  logic             cyc_load, cyc_inc;

  always_comb begin
    l0_valid    = (state_q == StL0) ? (batch_q & ~l0_done_q) : '0;
    l0_hs       = l0_valid & l0_flush_ready_i;
    l0_done_nxt = l0_done_q | l0_hs;
    cyc_load    = (state_q == StIdle) && (|pending_q);
    cyc_inc     = (state_q != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      batch_q    <= '0;
      l0_done_q  <= '0;
      last_cyc_q <= '0;
    end else begin
      // Requests always accumulate; a port already pending or in flight merges.
      pending_q <= pending_q | flush_valid_i;
      unique case (state_q)
        StIdle: begin
          if (|pending_q) begin
            batch_q   <= pending_q;
            pending_q <= flush_valid_i;
            state_q   <= L1_FLUSH_EN ? StL1 : StL0;
          end
        end
        StL1: begin
          if (l1_flush_ready_i) begin
            state_q <= StL0;
          end
        end
        StL0: begin
          l0_done_q <= l0_done_nxt;
          if ((batch_q & ~l0_done_nxt) == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          batch_q    <= '0;
          l0_done_q  <= '0;
          last_cyc_q <= cyc_cnt;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  cluster_icache_sat_cnt #(
    .Width(CYC_W)
  ) u_cyc_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (1'b0),
    .load_i    (cyc_load),
    .load_val_i(CYC_W'(1)),
    .inc_i     (cyc_inc),
    .cnt_o     (cyc_cnt)
  );

  assign flush_ready_o       = ~(pending_q | batch_q);
  assign l1_flush_valid_o    = (state_q == StL1);
  assign l0_flush_valid_o    = l0_valid;
  assign busy_o              = (state_q != StIdle);
  assign last_flush_cycles_o = last_cyc_q;

endmodule

// File: tb/tb_cluster_icache_flush_seq.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model, on one L1-enabled and one L1-disabled instance.
module tb_cluster_icache_flush_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fv_a, fv_b, l0r_a, l0r_b, frdy_a, frdy_b, l0v_a, l0v_b;
  logic       l1r_a, l1r_b, l1v_a, l1v_b, busy_a, busy_b;
  logic [15:0] last_a;
  logic [3:0]  last_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cluster_icache_flush_seq #(
    .NR_FETCH_PORTS(4), .L1_FLUSH_EN(1'b1), .CYC_W(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_valid_i(fv_a), .flush_ready_o(frdy_a),
    .l1_flush_valid_o(l1v_a), .l1_flush_ready_i(l1r_a), .l0_flush_valid_o(l0v_a),
    .l0_flush_ready_i(l0r_a), .busy_o(busy_a), .last_flush_cycles_o(last_a)
  );

  cluster_icache_flush_seq #(
    .NR_FETCH_PORTS(4), .L1_FLUSH_EN(1'b0), .CYC_W(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_valid_i(fv_b), .flush_ready_o(frdy_b),
    .l1_flush_valid_o(l1v_b), .l1_flush_ready_i(l1r_b), .l0_flush_valid_o(l0v_b),
    .l0_flush_ready_i(l0r_b), .busy_o(busy_b), .last_flush_cycles_o(last_b)
  );

  // Phase: 0 waiting, 1 flushing L1, 2 flushing L0s, 3 wrap-up cycle.
  typedef struct {
    int          phase;
    bit [3:0]    pend;
    bit [3:0]    bat;
    bit [3:0]    dn;
    int unsigned cnt;
    int unsigned last;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_step(mdl_t m, bit l1en, int unsigned maxc, bit r,
                                    bit [3:0] fv, bit l1r, bit [3:0] l0r);
    mdl_t n;
    n = m;
    if (r) begin
      n.phase = 0; n.pend = '0; n.bat = '0; n.dn = '0; n.cnt = 0; n.last = 0;
      return n;
    end
    n.pend = m.pend | fv;
    if (m.phase != 0) n.cnt = (m.cnt < maxc) ? m.cnt + 1 : maxc;
    case (m.phase)
      0: if (m.pend != 0) begin
        n.bat = m.pend; n.pend = fv; n.cnt = 1; n.phase = l1en ? 1 : 2;
      end
      1: if (l1r) n.phase = 2;
      2: begin
        n.dn = m.dn | (m.bat & ~m.dn & l0r);
        if ((m.bat & ~n.dn) == 0) n.phase = 3;
      end
      default: begin
        n.last = m.cnt; n.bat = '0; n.dn = '0; n.phase = 0;
      end
    endcase
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    bit [3:0] er, ev;
    er = ~(ma.pend | ma.bat);
    ev = (ma.phase == 2) ? (ma.bat & ~ma.dn) : 4'h0;
    check_eq("a_flush_ready", 32'(frdy_a), 32'(er));
    check_eq("a_l1_valid", 32'(l1v_a), 32'(ma.phase == 1));
    check_eq("a_l0_valid", 32'(l0v_a), 32'(ev));
    check_eq("a_busy", 32'(busy_a), 32'(ma.phase != 0));
    check_eq("a_last_cycles", 32'(last_a), ma.last);
    er = ~(mb.pend | mb.bat);
    ev = (mb.phase == 2) ? (mb.bat & ~mb.dn) : 4'h0;
    check_eq("b_flush_ready", 32'(frdy_b), 32'(er));
    check_eq("b_l1_valid", 32'(l1v_b), 32'(mb.phase == 1));
    check_eq("b_l0_valid", 32'(l0v_b), 32'(ev));
    check_eq("b_busy", 32'(busy_b), 32'(mb.phase != 0));
    check_eq("b_last_cycles", 32'(last_b), mb.last);
  endtask

  // Compare this cycle's outputs, then advance DUTs and models by one edge.
  task automatic tick();
    check_model();
    @(posedge clk);
    ma = mdl_step(ma, 1'b1, 32'hffff, rst, fv_a, l1r_a, l0r_a);
    mb = mdl_step(mb, 1'b0, 32'hf, rst, fv_b, l1r_b, l0r_b);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fv_a = '0; fv_b = '0; l0r_a = '0; l0r_b = '0; l1r_a = 1'b0; l1r_b = 1'b0;
    ma = mdl_step(ma, 1'b1, 32'hffff, 1'b1, 4'h0, 1'b0, 4'h0);
    mb = mdl_step(mb, 1'b0, 32'hf, 1'b1, 4'h0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    check_eq("rst_flush_ready", 32'(frdy_a), 32'hf);
    check_eq("rst_valids", 32'({l1v_a, l0v_a, l1v_b, l0v_b}), 32'h0);
    check_eq("rst_busy", 32'({busy_a, busy_b}), 32'h0);
    check_eq("rst_last", 32'(last_a), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Minimum-latency single-port flush.
    l1r_a = 1'b1; l0r_a = 4'hf;
    fv_a = 4'b0100; tick(); fv_a = '0;
    check_eq("lat_t1_ready", 32'(frdy_a[2]), 32'h0);
    check_eq("lat_t1_l1v", 32'(l1v_a), 32'h0);
    tick();
    check_eq("lat_t2_l1v", 32'(l1v_a), 32'h1);
    tick();
    check_eq("lat_t3_l0v", 32'(l0v_a), 32'h4);
    tick();
    check_eq("lat_t4_busy", 32'(busy_a), 32'h1);
    check_eq("lat_t4_ready", 32'(frdy_a[2]), 32'h0);
    tick();
    check_eq("lat_t5_ready", 32'(frdy_a), 32'hf);
    check_eq("lat_last", 32'(last_a), 32'd3);
    tick();

    // L1 backpressure for 20 cycles.
    l1r_a = 1'b0;
    fv_a = 4'b0001; tick(); fv_a = '0; tick();
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_l1v_hold", 32'(l1v_a), 32'h1);
      check_eq("bp_no_l0v", 32'(l0v_a), 32'h0);
      tick();
    end
    l1r_a = 1'b1;
    tick();
    check_eq("bp_l0v", 32'(l0v_a), 32'h1);
    tick(); tick();
    check_eq("bp_last", 32'(last_a), 32'd23);
    tick();

    // Out-of-order L0 completion.
    l0r_a = '0;
    fv_a = 4'b1011; tick(); fv_a = '0; tick(); tick();
    check_eq("ooo_l0v_all", 32'(l0v_a), 32'hb);
    tick(); tick();
    l0r_a = 4'b1000; tick(); l0r_a = '0;
    check_eq("ooo_after_p3", 32'(l0v_a), 32'h3);
    tick(); tick();
    l0r_a = 4'b0001; tick(); l0r_a = '0;
    check_eq("ooo_after_p0", 32'(l0v_a), 32'h2);
    tick(); tick();
    l0r_a = 4'b0010; tick(); l0r_a = '0;
    check_eq("ooo_done_busy", 32'(busy_a), 32'h1);
    check_eq("ooo_done_ready", 32'(frdy_a), 32'h4);
    tick();
    check_eq("ooo_release", 32'(frdy_a), 32'hf);
    tick();

    // Request arriving while a batch is in L0.
    l0r_a = 4'hf;
    fv_a = 4'b0001; tick(); fv_a = '0;
    check_eq("rdb_p0_low", 32'(frdy_a[0]), 32'h0); tick();
    check_eq("rdb_p0_low", 32'(frdy_a[0]), 32'h0);
    tick();
    check_eq("rdb_first_l0v", 32'(l0v_a), 32'h1);
    fv_a = 4'b0011; tick(); fv_a = '0;
    for (int i = 0; i < 2; i++) begin
      check_eq("rdb_p0_low", 32'(frdy_a[0]), 32'h0); tick();
    end
    check_eq("rdb_second_l1", 32'(l1v_a), 32'h1);
    check_eq("rdb_p0_low", 32'(frdy_a[0]), 32'h0); tick();
    check_eq("rdb_second_l0v", 32'(l0v_a), 32'h3);
    check_eq("rdb_p0_low", 32'(frdy_a[0]), 32'h0); tick();
    check_eq("rdb_p0_low", 32'(frdy_a[0]), 32'h0); tick();
    check_eq("rdb_release", 32'(frdy_a), 32'hf);
    tick();

    // No-L1 instance: L0 valids two cycles after the pulse, then saturation.
    l0r_b = 4'hf;
    fv_b = 4'hf; tick(); fv_b = '0;
    check_eq("nol1_t1_l0v", 32'(l0v_b), 32'h0); tick();
    check_eq("nol1_t2_l0v", 32'(l0v_b), 32'hf);
    check_eq("nol1_no_l1v", 32'(l1v_b), 32'h0);
    tick(); tick();
    check_eq("nol1_last", 32'(last_b), 32'd2);
    l0r_b = '0;
    fv_b = 4'b0001; tick(); fv_b = '0;
    for (int i = 0; i < 20; i++) tick();
    l0r_b = 4'hf; tick(); tick(); tick();
    check_eq("sat_last", 32'(last_b), 32'hf);

    // Reset while in L0.
    l0r_a = '0;
    fv_a = 4'b0110; tick(); fv_a = '0; tick(); tick();
    check_eq("rst_mid_l0v", 32'(l0v_a), 32'h6);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_mid_valids", 32'({l1v_a, l0v_a}), 32'h0);
    check_eq("rst_mid_ready", 32'(frdy_a), 32'hf);
    check_eq("rst_mid_busy", 32'(busy_a), 32'h0);
    l0r_a = 4'hf;
    fv_a = 4'b1000; tick(); fv_a = '0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rst_after_ready", 32'(frdy_a), 32'hf);
    check_eq("rst_after_last", 32'(last_a), 32'd3);

    // Random traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      fv_a  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      fv_b  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      l1r_a = ($urandom_range(0, 2) != 0);
      l1r_b = 1'($urandom);
      l0r_a = 4'($urandom);
      l0r_b = 4'($urandom);
      rst   = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; fv_a = '0; fv_b = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
